// File: rtl/bridge2xheep_pkg.sv
// Shared types, default widths and helpers for the CW305-to-X-HEEP OBI burst control unit.
package bridge2xheep_pkg;

  localparam int unsigned ADDR_W_DEF         = 32;
  localparam int unsigned DATA_W_DEF         = 32;
  localparam int unsigned LEN_W_DEF          = 8;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 1024;
  localparam int unsigned MAX_BE_W           = 64;

  typedef enum logic [2:0] {
    IDLE,
    FETCH_WDATA,
    REQ,
    RESP,
    DONE
  } state_t;

  function automatic logic [MAX_BE_W-1:0] be_all_ones(input int unsigned data_w);
    logic [MAX_BE_W-1:0] be;
    be = '0;
    for (int unsigned i = 0; i < MAX_BE_W; i++) begin
      if (i < data_w / 8) be[i] = 1'b1;
    end
    return be;
  endfunction

endpackage

// File: rtl/bridge2xheep_addr_gen.sv
// Burst address register (load / per-beat increment) and remaining-beat down-counter.
module bridge2xheep_addr_gen
  import bridge2xheep_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned LEN_W  = LEN_W_DEF,
  parameter int unsigned STEP   = DATA_W_DEF / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              advance,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [LEN_W-1:0]  len,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  logic [LEN_W-1:0] remaining;

  // Address wraps silently modulo 2^ADDR_W.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr      <= '0;
      remaining <= '0;
    end else if (load) begin
      addr      <= start_addr;
      remaining <= len;
    end else if (advance) begin
      addr      <= addr + ADDR_W'(STEP);
      remaining <= remaining - LEN_W'(1);
    end
  end

  assign last = (remaining == '0);

endmodule

// File: rtl/bridge2xheep_obi_burst_cu.sv
// Burst control unit: one host command per burst onto a single-outstanding OBI master port.
// Optional per-beat stall timeout enabled by defining BRIDGE2XHEEP_TIMEOUT_EN.
module bridge2xheep_obi_burst_cu
  import bridge2xheep_pkg::*;
#(
  parameter int unsigned ADDR_W         = ADDR_W_DEF,
  parameter int unsigned DATA_W         = DATA_W_DEF,
  parameter int unsigned LEN_W          = LEN_W_DEF,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_we,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [LEN_W-1:0]    cmd_len,
  input  logic                wdata_valid,
  output logic                wdata_ready,
  input  logic [DATA_W-1:0]   wdata_i,
  output logic                rdata_valid,
  output logic [DATA_W-1:0]   rdata_o,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic                obi_req,
  input  logic                obi_gnt,
  output logic [ADDR_W-1:0]   obi_addr,
  output logic                obi_we,
  output logic [DATA_W/8-1:0] obi_be,
  output logic [DATA_W-1:0]   obi_wdata,
  input  logic                obi_rvalid,
  input  logic [DATA_W-1:0]   obi_rdata
);

  localparam int unsigned BE_W = DATA_W / 8;
  localparam logic [MAX_BE_W-1:0] BE_FULL = be_all_ones(DATA_W);

  state_t            state;
  logic              we_q;
  logic [DATA_W-1:0] wdata_q;
  logic              last;
  logic              load;
  logic              advance;
  logic              abort;

  assign load    = (state == IDLE) && cmd_valid;
  assign advance = (state == RESP) && obi_rvalid && !last;

  bridge2xheep_addr_gen #(
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W),
    .STEP   (BE_W)
  ) u_addr_gen (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .advance    (advance),
    .start_addr (cmd_addr),
    .len        (cmd_len),
    .addr       (obi_addr),
    .last       (last)
  );

  assign obi_we    = obi_req & we_q;
  assign obi_be    = obi_req ? BE_FULL[BE_W-1:0] : '0;
  assign obi_wdata = wdata_q;

`ifdef BRIDGE2XHEEP_TIMEOUT_EN
  localparam int unsigned STALL_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [STALL_W-1:0] stall_cnt;
  logic               progress;
  logic               err_q;

  assign progress = ((state == REQ) && obi_gnt) || ((state == RESP) && obi_rvalid);
  assign abort    = ((state == REQ) || (state == RESP)) && !progress &&
                    (stall_cnt == STALL_W'(TIMEOUT_CYCLES - 1));
  assign err      = err_q;

  // Leaving REQ/RESP (or never being in them) zeroes the counter, so each entry starts at 0.
  always_ff @(posedge clk) begin
    if (rst || progress || !((state == REQ) || (state == RESP))) stall_cnt <= '0;
    else                                                         stall_cnt <= stall_cnt + STALL_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst)       err_q <= 1'b0;
    else if (load) err_q <= 1'b0;
    else if (abort) err_q <= 1'b1;
  end
`else
  assign abort = 1'b0 & (TIMEOUT_CYCLES != 0);
  assign err   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cmd_ready   <= 1'b1;
      wdata_ready <= 1'b0;
      obi_req     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      rdata_valid <= 1'b0;
      rdata_o     <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
    end else begin
      done        <= 1'b0;
      rdata_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (cmd_valid) begin
            we_q      <= cmd_we;
            busy      <= 1'b1;
            cmd_ready <= 1'b0;
            if (cmd_we) begin
              state       <= FETCH_WDATA;
              wdata_ready <= 1'b1;
            end else begin
              state   <= REQ;
              obi_req <= 1'b1;
            end
          end
        end
        FETCH_WDATA: begin
          if (wdata_valid) begin
            wdata_q     <= wdata_i;
            wdata_ready <= 1'b0;
            obi_req     <= 1'b1;
            state       <= REQ;
          end
        end
        REQ: begin
          if (obi_gnt) begin
            obi_req <= 1'b0;
            state   <= RESP;
          end else if (abort) begin
            obi_req <= 1'b0;
            done    <= 1'b1;
            state   <= DONE;
          end
        end
        RESP: begin
          if (obi_rvalid) begin
            if (!we_q) begin
              rdata_valid <= 1'b1;
              rdata_o     <= obi_rdata;
            end
            if (last) begin
              done  <= 1'b1;
              state <= DONE;
            end else if (we_q) begin
              wdata_ready <= 1'b1;
              state       <= FETCH_WDATA;
            end else begin
              obi_req <= 1'b1;
              state   <= REQ;
            end
          end else if (abort) begin
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bridge2xheep_obi_burst_cu.sv
// Scoreboard bench for bridge2xheep_obi_burst_cu: OBI responder/monitors check against queued expectations.
module tb_bridge2xheep_obi_burst_cu;

  localparam logic [31:0] MAGIC = 32'hA5A5A5A5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_we = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [7:0]  cmd_len = '0;
  logic        wdata_valid = 1'b0;
  logic        wdata_ready;
  logic [31:0] wdata_i = '0;
  logic        rdata_valid;
  logic [31:0] rdata_o;
  logic        busy;
  logic        done;
  logic        err;
  logic        obi_req;
  logic        obi_gnt = 1'b0;
  logic [31:0] obi_addr;
  logic        obi_we;
  logic [3:0]  obi_be;
  logic [31:0] obi_wdata;
  logic        obi_rvalid = 1'b0;
  logic [31:0] obi_rdata = '0;

  bridge2xheep_obi_burst_cu #(
    .ADDR_W         (32),
    .DATA_W         (32),
    .LEN_W          (8),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_we      (cmd_we),
    .cmd_addr    (cmd_addr),
    .cmd_len     (cmd_len),
    .wdata_valid (wdata_valid),
    .wdata_ready (wdata_ready),
    .wdata_i     (wdata_i),
    .rdata_valid (rdata_valid),
    .rdata_o     (rdata_o),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .obi_req     (obi_req),
    .obi_gnt     (obi_gnt),
    .obi_addr    (obi_addr),
    .obi_we      (obi_we),
    .obi_be      (obi_be),
    .obi_wdata   (obi_wdata),
    .obi_rvalid  (obi_rvalid),
    .obi_rdata   (obi_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
  } req_t;

  typedef struct {
    logic err;
    int   acc;
    int   lat;
  } done_t;

  req_t        exp_req[$];
  logic [31:0] exp_rd[$];
  done_t       exp_done[$];
  logic [31:0] wq[$];

  int          n_cmp = 0;
  int          n_bad = 0;
  int          gnt_delay = 0;
  int          wdata_delay = 0;
  bit          gnt_en = 1'b1;
  bit          pending_r = 1'b0;
  logic [31:0] resp_data = '0;
  int          gnt_count = 0;
  int          done_count = 0;
  int          dones = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // OBI slave: grant after gnt_delay req cycles, respond one cycle after grant with addr^MAGIC.
  initial begin : responder
    int          wait_cnt;
    bit          first;
    logic [31:0] hold_addr;
    logic [31:0] hold_wdata;
    req_t        e;
    wait_cnt = 0;
    first    = 1'b1;
    forever begin
      @(negedge clk);
      obi_rvalid = pending_r;
      obi_rdata  = pending_r ? resp_data : '0;
      pending_r  = 1'b0;
      obi_gnt    = 1'b0;
      if (obi_req === 1'b1) begin
        if (first) begin
          hold_addr  = obi_addr;
          hold_wdata = obi_wdata;
          first      = 1'b0;
        end else begin
          check("req_addr_stable", obi_addr, hold_addr);
          check("req_wdata_stable", obi_wdata, hold_wdata);
        end
        check("req_be", obi_be, 4'hF);
        if (gnt_en && wait_cnt >= gnt_delay) begin
          obi_gnt   = 1'b1;
          pending_r = 1'b1;
          resp_data = obi_addr ^ MAGIC;
          wait_cnt  = 0;
          first     = 1'b1;
          gnt_count++;
          if (exp_req.size() == 0) begin
            check("req_unexpected", obi_req, 1'b0);
          end else begin
            e = exp_req.pop_front();
            check("req_addr", obi_addr, e.addr);
            check("req_we", obi_we, e.we);
            if (e.we) check("req_wdata", obi_wdata, e.wdata);
          end
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
        first    = 1'b1;
      end
    end
  end

  // Host write-data source: presents queued words, optionally after wdata_delay ready cycles.
  initial begin : feeder
    bit take;
    int dly_cnt;
    take    = 1'b0;
    dly_cnt = 0;
    forever begin
      @(negedge clk);
      if (take) begin
        void'(wq.pop_front());
        wdata_valid = 1'b0;
        dly_cnt     = 0;
      end
      if (wq.size() > 0 && !wdata_valid) begin
        if (dly_cnt >= wdata_delay) begin
          wdata_valid = 1'b1;
          wdata_i     = wq[0];
        end else if (wdata_ready) begin
          dly_cnt++;
        end
      end
      take = wdata_valid && wdata_ready;
    end
  end

  // Host-side monitor: read beats and burst completion.
  initial begin : monitor
    done_t d;
    forever begin
      @(negedge clk);
      if (rdata_valid === 1'b1) begin
        if (exp_rd.size() == 0) check("rdata_unexpected", rdata_valid, 1'b0);
        else                    check("rdata", rdata_o, exp_rd.pop_front());
      end
      if (done === 1'b1) begin
        done_count++;
        if (exp_done.size() == 0) begin
          check("done_unexpected", done, 1'b0);
        end else begin
          d = exp_done.pop_front();
          check("done_err", err, d.err);
          if (d.lat >= 0) check("done_latency", cyc - d.acc, d.lat);
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_cmd(input logic we, input logic [31:0] addr, input logic [7:0] len,
                          input bit want_done, input int lat, input logic exp_err);
    done_t d;
    bit    ok;
    ok = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_addr  = addr;
    cmd_len   = len;
    for (int i = 0; i < 50; i++) begin
      if (cmd_ready === 1'b1) begin
        ok = 1'b1;
        if (want_done) begin
          d.err = exp_err;
          d.acc = cyc;
          d.lat = lat;
          exp_done.push_back(d);
          dones++;
        end
        break;
      end
      @(negedge clk);
    end
    check("cmd_accepted", ok, 1'b1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(posedge clk);
      if (done_count >= dones) begin
        ok = 1'b1;
        break;
      end
    end
    check("done_seen", ok, 1'b1);
    repeat (2) @(negedge clk);
  endtask

  task automatic push_rd(input logic [31:0] addr);
    req_t r;
    r.addr  = addr;
    r.we    = 1'b0;
    r.wdata = '0;
    exp_req.push_back(r);
    exp_rd.push_back(addr ^ MAGIC);
  endtask

  task automatic push_wr(input logic [31:0] addr, input logic [31:0] data);
    req_t r;
    r.addr  = addr;
    r.we    = 1'b1;
    r.wdata = data;
    exp_req.push_back(r);
    wq.push_back(data);
  endtask

  initial begin : stimulus
    int base;
    int n;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_obi_req", obi_req, 1'b0);
    check("rst_wdata_ready", wdata_ready, 1'b0);
    check("rst_rdata_valid", rdata_valid, 1'b0);
    check("rst_obi_addr", obi_addr, 32'h0);
    check("rst_obi_be", obi_be, 4'h0);

    // Single write, everything immediate: done 4 cycles after accept.
    push_wr(32'h0000_1000, 32'hDEAD_BEEF);
    send_cmd(1'b1, 32'h0000_1000, 8'd0, 1'b1, 4, 1'b0);
    wait_done();

    // Four-beat read burst.
    push_rd(32'h0000_2000);
    push_rd(32'h0000_2004);
    push_rd(32'h0000_2008);
    push_rd(32'h0000_200C);
    send_cmd(1'b0, 32'h0000_2000, 8'd3, 1'b1, -1, 1'b0);
    wait_done();

    // Backpressure on both grant and write data.
    gnt_delay   = 5;
    wdata_delay = 3;
    push_wr(32'h0000_4000, 32'h1111_1111);
    push_wr(32'h0000_4004, 32'h2222_2222);
    send_cmd(1'b1, 32'h0000_4000, 8'd1, 1'b1, -1, 1'b0);
    wait_done();
    gnt_delay   = 0;
    wdata_delay = 0;

    // Address wrap.
    push_rd(32'hFFFF_FFFC);
    push_rd(32'h0000_0000);
    send_cmd(1'b0, 32'hFFFF_FFFC, 8'd1, 1'b1, -1, 1'b0);
    wait_done();

    // Reset during RESP of the second beat of four.
    push_rd(32'h0000_3000);
    req_push_second : begin
      req_t r;
      r.addr  = 32'h0000_3004;
      r.we    = 1'b0;
      r.wdata = '0;
      exp_req.push_back(r);
    end
    base = gnt_count;
    send_cmd(1'b0, 32'h0000_3000, 8'd3, 1'b0, -1, 1'b0);
    n = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      if (gnt_count >= base + 2) begin
        n = 1;
        break;
      end
    end
    check("reset_test_reached_beat2", n, 1);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_obi_req", obi_req, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_cmd_ready", cmd_ready, 1'b1);
    check("midrst_done", done, 1'b0);
    push_rd(32'h0000_6000);
    send_cmd(1'b0, 32'h0000_6000, 8'd0, 1'b1, -1, 1'b0);
    wait_done();

`ifdef BRIDGE2XHEEP_TIMEOUT_EN
    // Grant never arrives: abort after 16 request cycles.
    gnt_en = 1'b0;
    send_cmd(1'b0, 32'h0000_5000, 8'd2, 1'b1, -1, 1'b1);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      if (obi_req === 1'b1) n++;
      else if (n > 0) break;
      @(negedge clk);
    end
    check("timeout_req_cycles", n, 16);
    wait_done();
    check("timeout_err_sticky", err, 1'b1);
    @(posedge clk);
    pending_r = 1'b1;
    repeat (3) @(negedge clk);
    check("stray_rvalid_busy", busy, 1'b0);
    check("stray_rvalid_err", err, 1'b1);
    gnt_en = 1'b1;
    push_rd(32'h0000_7000);
    send_cmd(1'b0, 32'h0000_7000, 8'd0, 1'b1, -1, 1'b0);
    check("err_cleared_on_accept", err, 1'b0);
    wait_done();
`endif

    check("exp_req_left", exp_req.size(), 0);
    check("exp_rd_left", exp_rd.size(), 0);
    check("exp_done_left", exp_done.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bridge2xheep_obi_burst_cu.md
Name: bridge2xheep_obi_burst_cu

Overview:
Next-generation control unit for the CW305-to-X-HEEP bridge. It accepts one host command per burst (read or write, start address, beat count) and drives a single-outstanding OBI master port. It auto-increments the address per beat, waits for both gnt and rvalid on every beat, and streams read data back to the host.
It sits between the CW305 register front-end and the X-HEEP system bus, and replaces the write-only, single-beat predecessor.

Parameters:
ADDR_W, 32, OBI address width
DATA_W, 32, OBI data width; must be a multiple of 8
LEN_W, 8, burst length field width; bursts are 1..2^LEN_W beats
TIMEOUT_CYCLES, 1024, stall limit per beat (used only with the optional feature)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
cmd_valid  in  1  host command valid
cmd_ready  out  1  command accepted when cmd_valid and cmd_ready are both 1
cmd_we  in  1  1 = write burst, 0 = read burst
cmd_addr  in  ADDR_W  start byte address
cmd_len  in  LEN_W  beats minus 1
wdata_valid  in  1  host write beat valid
wdata_ready  out  1  host write beat accepted
wdata_i  in  DATA_W  host write data
rdata_valid  out  1  one-cycle pulse carrying a read beat
rdata_o  out  DATA_W  read beat data
busy  out  1  burst in progress
done  out  1  one-cycle pulse at burst end
err  out  1  burst aborted; sticky until the next command is accepted
obi_req  out  1  OBI request
obi_gnt  in  1  OBI grant
obi_addr  out  ADDR_W  OBI address
obi_we  out  1  OBI write enable
obi_be  out  DATA_W/8  OBI byte enables
obi_wdata  out  DATA_W  OBI write data
obi_rvalid  in  1  OBI response valid
obi_rdata  in  DATA_W  OBI response data

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values: state IDLE; all outputs 0 except cmd_ready = 1; address, beat counter and data registers cleared.
- Reset mid-burst: at the next edge the block returns to IDLE with obi_req = 0. Any pending rvalid is ignored because rvalid is don't-care in IDLE.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid, latch addr, we and len, clear err, set busy.
  - Go to FETCH_WDATA if cmd_we = 1, else to REQ.
- FETCH_WDATA:
  - wdata_ready = 1.
  - On wdata_valid, latch wdata_i into the write register and go to REQ.
- REQ:
  - obi_req = 1; obi_we = latched we; obi_be = all ones; obi_addr and obi_wdata come from registers and are stable.
  - req stays high until gnt. On gnt, go to RESP; req drops the following cycle.
- RESP:
  - Wait for obi_rvalid.
  - On a read burst, rdata_o = obi_rdata registered, with a rdata_valid pulse the cycle after rvalid.
  - Then, if beats remaining = 0, go to DONE. Otherwise increment addr, decrement the beat counter, and go to FETCH_WDATA (write) or REQ (read).
- DONE: done = 1 for one cycle; busy = 0 from the following cycle; return to IDLE.
- Address arithmetic: addr += DATA_W/8 per beat, modulo 2^ADDR_W. Wrap-around is silent.
- Beat counter: width LEN_W. A burst with cmd_len = 2^LEN_W-1 issues 2^LEN_W beats.
- Outstanding transactions: exactly one. No new req is issued before rvalid of the previous beat.
- Simultaneous events: gnt and rvalid in the same cycle while in REQ is illegal for OBI; rvalid is only honoured in RESP. A cmd_valid while busy is ignored, since cmd_ready = 0.
- Minimum single-beat write latency (wdata already valid, gnt immediate, rvalid one cycle after gnt): cmd accept → done pulse = 4 cycles (FETCH, REQ, RESP, DONE).

Optional Feature:
BRIDGE2XHEEP_TIMEOUT_EN
- With it: a stall counter is reset on every state entry and counts cycles spent in REQ or RESP.
  - On reaching TIMEOUT_CYCLES: drop obi_req, set err = 1, skip the remaining beats, go to DONE (done still pulses).
  - rvalid arriving after an abort is ignored.
- Without it: no counter is built, err is tied to 0, and the block waits indefinitely.

Decomposition:
- Package bridge2xheep_pkg holds:
  - the state enum (IDLE, FETCH_WDATA, REQ, RESP, DONE);
  - the default width localparams;
  - a function returning the all-ones byte enable for DATA_W.
- One sub-module: bridge2xheep_addr_gen, containing the address register with load/increment and the beat down-counter with load/decrement and a last-beat flag.

Test Plan:
- Single write: addr 0x1000, len 0, wdata 0xDEADBEEF, gnt immediate, rvalid +1 → one req, obi_addr 0x1000, obi_be 0xF, done 4 cycles after accept.
- Read burst: addr 0x2000, len 3, memory model returning addr^0xA5A5A5A5 → 4 reqs at 0x2000/04/08/0C, 4 rdata_valid pulses with matching data, done once.
- Backpressure: gnt delayed by 5 cycles and wdata_valid delayed by 3 → req held stable with constant addr/wdata, no duplicate beats.
- Wrap: addr 0xFFFFFFFC, len 1 → second beat at 0x00000000.
- Reset asserted during RESP of beat 2 of 4 → next cycle req = 0, busy = 0, cmd_ready = 1; a following command runs cleanly.
- With BRIDGE2XHEEP_TIMEOUT_EN and TIMEOUT_CYCLES = 16, gnt never asserted → req drops after 16 cycles, err = 1, done pulses, rvalid afterwards has no effect.
